// File: rtl/debouncer_botoes.sv
// -----------------------------------------------------------------------------
// debouncer_botoes
//
// Cleans N mechanical keys/switches into stable, clock-synchronous levels plus
// one-cycle press/release pulses. Intended to sit directly upstream of a small
// register: pulso_press drives the register enable and nivel drives the data or
// select lines. This replaces raw switches used as clocks or enables.
//
// Each channel has:
//   - a 2-FF synchronizer on the raw input;
//   - polarity normalization, so that p = 1 always means "pressed";
//   - a stable-time counter. A new level is accepted only after it has been
//     seen for CICLOS_ESTAVEIS consecutive cycles.
//
// Parameters
//   N_BOTOES         number of independent channels (>= 1)
//   CICLOS_ESTAVEIS  consecutive cycles a new level must hold (>= 1)
//   ATIVO_BAIXO      1: raw 0 = pressed; 0: raw 1 = pressed
//
// Ports
//   clk          in   1         system clock, rising edge
//   rst          in   1         asynchronous reset, active low
//   botao        in   N_BOTOES  raw asynchronous key/switch inputs
//   nivel        out  N_BOTOES  debounced level, 1 = pressed
//   pulso_press  out  N_BOTOES  1-cycle pulse when nivel[i] goes 0->1
//   pulso_solta  out  N_BOTOES  1-cycle pulse when nivel[i] goes 1->0
//   algum_press  out  1         OR of pulso_press (registered, aligned)
//
// Latency: a raw change first sampled at edge E0 appears on nivel and on the
// pulses at edge E0+1+CICLOS_ESTAVEIS, provided the raw input stays constant.
// -----------------------------------------------------------------------------
module debouncer_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int CICLOS_ESTAVEIS = 1000000,
    parameter bit ATIVO_BAIXO     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] botao,
    output logic [N_BOTOES-1:0] nivel,
    output logic [N_BOTOES-1:0] pulso_press,
    output logic [N_BOTOES-1:0] pulso_solta,
    output logic                algum_press
);

    // The counter must be able to hold CICLOS_ESTAVEIS-1. It is cleared on
    // acceptance, so it never wraps.
    localparam int unsigned CW = (CICLOS_ESTAVEIS > 1) ? $clog2(CICLOS_ESTAVEIS + 1) : 1;
    localparam logic [CW-1:0] LIMITE  = CW'(CICLOS_ESTAVEIS - 1);

    // Raw level of a released key. The synchronizers reset to this level, so
    // a key held through reset is reported as a fresh press afterwards.
    localparam logic INATIVO = ATIVO_BAIXO;

    // Next-state press pulses of all channels, used to register algum_press.
    logic [N_BOTOES-1:0] press_d_all;
    logic                algum_q;
    logic                algum_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_BOTOES; gi++) begin : g_canal
            logic          s1_q;
            logic          s2_q;
            logic          p;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          nivel_q;
            logic          nivel_d;
            logic          press_q;
            logic          press_d;
            logic          solta_q;
            logic          solta_d;

            // Normalized, synchronized input: 1 = pressed.
            assign p = s2_q ^ INATIVO;

            always_comb begin
                cnt_d   = cnt_q;
                nivel_d = nivel_q;
                press_d = 1'b0;
                solta_d = 1'b0;
                if (p == nivel_q) begin
                    // Input agrees with the accepted level. Any bounce back
                    // lands here and restarts the stability window.
                    cnt_d = '0;
                end else if (cnt_q >= LIMITE) begin
                    // The new level has held long enough, so accept it and
                    // emit exactly one pulse in its direction.
                    nivel_d = p;
                    cnt_d   = '0;
                    press_d = p;
                    solta_d = ~p;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_q    <= INATIVO;
                    s2_q    <= INATIVO;
                    cnt_q   <= '0;
                    nivel_q <= 1'b0;
                    press_q <= 1'b0;
                    solta_q <= 1'b0;
                end else begin
                    s1_q    <= botao[gi];
                    s2_q    <= s1_q;
                    cnt_q   <= cnt_d;
                    nivel_q <= nivel_d;
                    press_q <= press_d;
                    solta_q <= solta_d;
                end
            end

            assign nivel[gi]       = nivel_q;
            assign pulso_press[gi] = press_q;
            assign pulso_solta[gi] = solta_q;
            assign press_d_all[gi] = press_d;
        end
    endgenerate

    // algum_press is built from the next-state pulses so that it is
    // registered and lines up with pulso_press in the same cycle.
    assign algum_d = |press_d_all;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            algum_q <= 1'b0;
        end else begin
            algum_q <= algum_d;
        end
    end

    assign algum_press = algum_q;

endmodule

// File: tb/tb_debouncer_botoes.sv
module tb_debouncer_botoes;

    localparam int N       = 4;
    localparam int CICLOS  = 8;
    localparam int LAT     = CICLOS + 2; // drive after edge c -> output at edge c+LAT

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] botao;
    logic [N-1:0] nivel;
    logic [N-1:0] pulso_press;
    logic [N-1:0] pulso_solta;
    logic         algum_press;

    debouncer_botoes #(
        .N_BOTOES        (N),
        .CICLOS_ESTAVEIS (CICLOS),
        .ATIVO_BAIXO     (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .botao       (botao),
        .nivel       (nivel),
        .pulso_press (pulso_press),
        .pulso_solta (pulso_solta),
        .algum_press (algum_press)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int n_vec  = 0;
    int n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ciclo;
        logic [N-1:0] press;
        logic [N-1:0] solta;
        logic [N-1:0] nivel;
    } ev_t;

    ev_t          sb[$];
    logic [N-1:0] exp_nivel = '0;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s obs=%b exp=%b cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    // Called right after driving a change (posedge + 1): result due LAT edges later.
    task automatic agenda(input logic [N-1:0] pr, input logic [N-1:0] so, input logic [N-1:0] nv);
        ev_t e;
        e.ciclo = cyc + LAT;
        e.press = pr;
        e.solta = so;
        e.nivel = nv;
        sb.push_back(e);
    endtask

    task automatic espera(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every cycle on the falling edge.
    always @(negedge clk) begin
        ev_t e;
        if (rst === 1'b0) begin
            check("reset_nivel", nivel, '0);
            check("reset_press", pulso_press, '0);
            check("reset_solta", pulso_solta, '0);
            check("reset_algum", {3'b000, algum_press}, '0);
        end else if (sb.size() > 0 && sb[0].ciclo == cyc) begin
            e = sb.pop_front();
            exp_nivel = e.nivel;
            check("ev_press", pulso_press, e.press);
            check("ev_solta", pulso_solta, e.solta);
            check("ev_nivel", nivel, e.nivel);
            check("ev_algum", {3'b000, algum_press}, {3'b000, |e.press});
        end else begin
            check("idle_press", pulso_press, '0);
            check("idle_solta", pulso_solta, '0);
            check("idle_algum", {3'b000, algum_press}, '0);
            check("idle_nivel", nivel, exp_nivel);
        end
    end

    initial begin
        // 1: reset
        botao = 4'b1111;
        rst   = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("async_reset_nivel", nivel, '0);
        check("async_reset_press", pulso_press, '0);
        espera(3);
        rst = 1'b1;
        espera(20);

        // 2: clean press/release ch0
        botao = 4'b1110;
        agenda(4'b0001, 4'b0000, 4'b0001);
        espera(15);
        botao = 4'b1111;
        agenda(4'b0000, 4'b0001, 4'b0000);
        espera(15);

        // 3: bounce ch1, 3-cycle segments, then hold pressed
        for (int k = 0; k < 10; k++) begin
            botao[1] = logic'(k % 2);
            espera(3);
        end
        botao[1] = 1'b0;
        agenda(4'b0010, 4'b0000, 4'b0010);
        espera(15);
        botao[1] = 1'b1;
        agenda(4'b0000, 4'b0010, 4'b0000);
        espera(15);

        // 4: glitch boundary ch2 (7 cycles rejected, 8 accepted)
        botao[2] = 1'b0;
        espera(7);
        botao[2] = 1'b1;
        espera(15);
        botao[2] = 1'b0;
        agenda(4'b0100, 4'b0000, 4'b0100);
        espera(8);
        botao[2] = 1'b1;
        agenda(4'b0000, 4'b0100, 4'b0000);
        espera(15);

        // 5: simultaneous press ch0 / release ch3
        botao[3] = 1'b0;
        agenda(4'b1000, 4'b0000, 4'b1000);
        espera(15);
        botao = 4'b1110;
        agenda(4'b0001, 4'b1000, 4'b0001);
        espera(15);
        botao = 4'b1111;
        agenda(4'b0000, 4'b0001, 4'b0000);
        espera(15);

        // 6: reset mid-operation with keys held
        botao[2] = 1'b0;
        agenda(4'b0100, 4'b0000, 4'b0100);
        espera(15);
        botao[0] = 1'b0;
        espera(5);
        #2;
        rst = 1'b0;
        sb.delete();
        exp_nivel = '0;
        #1;
        check("midrst_nivel", nivel, '0);
        check("midrst_press", pulso_press, '0);
        espera(4);
        rst = 1'b1;
        agenda(4'b0101, 4'b0000, 4'b0101);
        espera(15);
        botao = 4'b1111;
        agenda(4'b0000, 4'b0101, 4'b0000);
        espera(15);

        n_vec++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drained obs=%0d exp=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
